// File: rtl/action_executor_if.sv
// rtl/action_executor_if.sv - byte link from the action executor to the kitchen transmitter
//   tx_data   command byte (master -> slave)
//   tx_valid  tx_data valid (master -> slave)
//   tx_ready  slave accepts the byte this cycle (slave -> master)
interface action_executor_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/action_executor.sv
// rtl/action_executor.sv - issues one-hot action commands as opcode/target byte pairs and awaits kitchen feedback
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   control_data  {move,get,put,interact,throw} level command, one-hot or zero
//   i_num         target machine number
//   feedbak_sig   kitchen state, bit2 = chef in front of target machine
//   tx            byte link master (tx_data, tx_valid, tx_ready)
//   busy          high whenever not IDLE
//   done          one-cycle pulse on successful completion
//   err           one-cycle pulse on timeout or illegal command
module action_executor #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           control_data,
    input  logic [7:0]           i_num,
    input  logic [7:0]           feedbak_sig,
    action_executor_if.master    tx,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE, SEND_OP, SEND_ARG, WAIT_FB, DONE, ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic             cmd_move;
    logic [7:0]       tgt;
    logic [7:0]       fb_ref;
    logic [4:0]       last_cmd;
    logic [CNT_W-1:0] counter;
    logic             armed;

    logic accept;
    logic legal;
    logic complete;
    logic handshake;

    assign accept    = (state == IDLE) && (control_data != 5'd0) && armed;
    assign legal     = (control_data & (control_data - 5'd1)) == 5'd0;
    // Move completes when the chef reaches the machine; every other action
    // completes on any change of kitchen state since the arg byte went out.
    assign complete  = cmd_move ? feedbak_sig[2] : (feedbak_sig != fb_ref);
    assign handshake = tx.tx_valid && tx.tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx.tx_data  <= 8'd0;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            counter     <= '0;
            armed       <= 1'b1;
            last_cmd    <= 5'd0;
            cmd_move    <= 1'b0;
            tgt         <= 8'd0;
            fb_ref      <= 8'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // A held level must drop or change before it can be accepted again.
            if (accept)
                armed <= 1'b0;
            else if (control_data == 5'd0 || control_data != last_cmd)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        // Illegal values are remembered too, so a held illegal
                        // level raises err only once.
                        last_cmd <= control_data;
                        if (legal) begin
                            cmd_move    <= control_data[4];
                            tgt         <= i_num;
                            tx.tx_data  <= {3'b101, control_data};
                            tx.tx_valid <= 1'b1;
                            busy        <= 1'b1;
                            state       <= SEND_OP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SEND_OP: begin
                    if (handshake) begin
                        tx.tx_data <= tgt;
                        state      <= SEND_ARG;
                    end
                end
                SEND_ARG: begin
                    if (handshake) begin
                        tx.tx_valid <= 1'b0;
                        fb_ref      <= feedbak_sig;
                        counter     <= '0;
                        state       <= WAIT_FB;
                    end
                end
                WAIT_FB: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (complete) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (counter == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DONE, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    tx.tx_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_executor.sv
// tb/tb_action_executor.sv - directed self-checking bench for action_executor
module tb_action_executor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] control_data;
    logic [7:0] i_num;
    logic [7:0] feedbak_sig;
    logic       busy, done, err;

    action_executor_if tx ();

    action_executor #(.TIMEOUT_CYC(16), .CNT_W(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .control_data (control_data),
        .i_num        (i_num),
        .feedbak_sig  (feedbak_sig),
        .tx           (tx.master),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] bytes[$];
    int         done_cnt = 0;
    int         err_cnt  = 0;

    // Inputs change 1 ns after posedge, so negedge sees the values the next edge will use.
    always @(negedge clk) begin
        if (tx.tx_valid && tx.tx_ready) bytes.push_back(tx.tx_data);
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        for (int i = 0; i < 30 && bytes.size() < n; i++) step();
        check(tag, bytes.size(), n);
    endtask

    task automatic wait_done(input int n, input string tag);
        for (int i = 0; i < 40 && done_cnt < n; i++) step();
        check(tag, done_cnt, n);
    endtask

    task automatic idle_cmd();
        control_data = 5'd0;
        step();
        step();
    endtask

    int nb, nd, ne;

    initial begin
        rst_n = 1'b0; control_data = 5'd0; i_num = 8'd0; feedbak_sig = 8'd0; tx.tx_ready = 1'b0;
        step(); step();
        probe();
        check("rst_busy",   busy, 0);
        check("rst_valid",  tx.tx_valid, 0);
        check("rst_data",   tx.tx_data, 0);
        check("rst_done",   done, 0);
        check("rst_err",    err, 0);
        step();
        rst_n = 1'b1;
        step();

        // 1: move, best-case latency
        nb = bytes.size(); nd = done_cnt;
        control_data = 5'b10000; i_num = 8'h03; tx.tx_ready = 1'b1;
        probe(); check("t1_busy_n0", busy, 0);
        step(); probe();
        check("t1_op_valid", tx.tx_valid, 1);
        check("t1_op_data", tx.tx_data, 8'hB0);
        check("t1_busy_n1", busy, 1);
        step(); probe();
        check("t1_arg_data", tx.tx_data, 8'h03);
        step(); feedbak_sig = 8'h04; probe();
        check("t1_wait_valid", tx.tx_valid, 0);
        check("t1_wait_done", done, 0);
        step(); probe();
        check("t1_done_n4", done, 1);
        check("t1_busy_n4", busy, 1);
        step(); probe();
        check("t1_done_off", done, 0);
        check("t1_busy_off", busy, 0);
        for (int i = 0; i < 10; i++) step();
        check("t1_nbytes", bytes.size() - nb, 2);
        if (bytes.size() >= nb + 2) begin
            check("t1_b0", bytes[nb], 8'hB0);
            check("t1_b1", bytes[nb+1], 8'h03);
        end
        check("t1_ndone", done_cnt - nd, 1);

        // 2: switch to get, feedback toggles later
        nb = bytes.size(); nd = done_cnt;
        control_data = 5'b01000;
        wait_bytes(nb + 2, "t2_bytes");
        step(); step(); step();
        check("t2_no_early_done", done_cnt - nd, 0);
        feedbak_sig = 8'h05;
        wait_done(nd + 1, "t2_done");
        for (int i = 0; i < 10; i++) step();
        check("t2_nbytes", bytes.size() - nb, 2);
        if (bytes.size() >= nb + 2) begin
            check("t2_b0", bytes[nb], 8'hA8);
            check("t2_b1", bytes[nb+1], 8'h03);
        end
        check("t2_ndone", done_cnt - nd, 1);
        check("t2_busy", busy, 0);

        // 3: backpressure on the opcode byte
        idle_cmd();
        nb = bytes.size(); nd = done_cnt;
        feedbak_sig = 8'h00; tx.tx_ready = 1'b0;
        control_data = 5'b10000; i_num = 8'h5A;
        step();
        for (int i = 0; i < 5; i++) begin
            probe();
            check("t3_hold_valid", tx.tx_valid, 1);
            check("t3_hold_data", tx.tx_data, 8'hB0);
            step();
        end
        check("t3_no_arg", bytes.size() - nb, 0);
        tx.tx_ready = 1'b1;
        wait_bytes(nb + 2, "t3_bytes");
        if (bytes.size() >= nb + 2) begin
            check("t3_b0", bytes[nb], 8'hB0);
            check("t3_b1", bytes[nb+1], 8'h5A);
        end
        feedbak_sig = 8'h04;
        wait_done(nd + 1, "t3_done");

        // 4: timeout after 16 cycles in WAIT_FB
        idle_cmd();
        nb = bytes.size(); nd = done_cnt; ne = err_cnt;
        control_data = 5'b00001; i_num = 8'h77;
        step(); step(); step();
        for (int i = 0; i < 15; i++) step();
        probe(); check("t4_err_early", err, 0);
        step(); probe();
        check("t4_err_16", err, 1);
        step(); probe();
        check("t4_busy_after", busy, 0);
        check("t4_nerr", err_cnt - ne, 1);
        check("t4_ndone", done_cnt - nd, 0);
        if (bytes.size() >= nb + 2) begin
            check("t4_b0", bytes[nb], 8'hA1);
            check("t4_b1", bytes[nb+1], 8'h77);
        end else begin
            check("t4_nbytes", bytes.size() - nb, 2);
        end

        // 5: illegal command
        idle_cmd();
        nb = bytes.size(); ne = err_cnt;
        control_data = 5'b00110;
        step(); probe();
        check("t5_err", err, 1);
        check("t5_valid", tx.tx_valid, 0);
        check("t5_busy", busy, 0);
        for (int i = 0; i < 10; i++) step();
        check("t5_held_nerr", err_cnt - ne, 1);
        check("t5_nbytes", bytes.size() - nb, 0);
        control_data = 5'd0; step();
        control_data = 5'b00110; step(); step();
        check("t5_rearm_nerr", err_cnt - ne, 2);

        // 6: reset during SEND_ARG under backpressure
        idle_cmd();
        nb = bytes.size();
        control_data = 5'b01000; i_num = 8'h11; tx.tx_ready = 1'b1;
        step();
        step(); tx.tx_ready = 1'b0;
        probe();
        check("t6_arg_valid", tx.tx_valid, 1);
        check("t6_arg_data", tx.tx_data, 8'h11);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", tx.tx_valid, 0);
        check("t6_rst_busy", busy, 0);
        step();
        control_data = 5'd0; rst_n = 1'b1;
        step();
        check("t6_no_arg", bytes.size() - nb, 1);
        nb = bytes.size(); nd = done_cnt;
        control_data = 5'b00100; i_num = 8'h22; tx.tx_ready = 1'b1;
        wait_bytes(nb + 2, "t6_bytes");
        if (bytes.size() >= nb + 2) begin
            check("t6_b0", bytes[nb], 8'hA4);
            check("t6_b1", bytes[nb+1], 8'h22);
        end
        feedbak_sig = 8'h99;
        wait_done(nd + 1, "t6_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
